// File: rtl/sample_accumulator.sv
// -----------------------------------------------------------------------------
// sample_accumulator
//   Sums a batch of NUM_SAMPLES unsigned 16-bit samples into a running total.
//   Samples are taken with a valid/ready handshake. The finished result is
//   held under sum_valid until the consumer pulses result_ack. The sum wraps
//   modulo 2^16, and a sticky flag records whether any add carried out.
//
// Ports
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   clear         in   synchronous abort to IDLE with all state zeroed
//   data_in       in   [15:0] sample value (unsigned)
//   data_valid    in   data_in valid this cycle
//   data_ready    out  block accepts a sample this cycle
//   sum_out       out  [15:0] accumulated sum (mod 2^16)
//   sum_valid     out  batch result is final
//   result_ack    in   consumer took the result (only looked at in DONE)
//   overflow_flag out  sticky carry-out seen during the batch
//   sample_count  out  [7:0] samples accepted in the current batch
// -----------------------------------------------------------------------------

// 16-bit ripple-style adder used as the accumulator datapath.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);

  logic [16:0] full_s;

  // Widen by one bit so the carry-out lands in the MSB.
  always_comb begin
    full_s   = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
    sum      = full_s[15:0];
    overflow = full_s[16];
  end

endmodule

module sample_accumulator #(
  parameter int NUM_SAMPLES = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [15:0] sum_out,
  output logic        sum_valid,
  input  logic        result_ack,
  output logic        overflow_flag,
  output logic [7:0]  sample_count
);

  // Batch length outside 1..255 cannot be represented by the 8-bit count.
  if (NUM_SAMPLES < 1 || NUM_SAMPLES > 255) begin : g_bad_num_samples
    $error("sample_accumulator: NUM_SAMPLES must be in 1..255");
  end

  localparam logic [7:0] LAST_COUNT = 8'(NUM_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic [15:0] add_sum_s;
  logic        add_ovf_s;
  logic        accept_s;
  logic        last_s;

  adder_16bit u_adder (
    .a        (acc_q),
    .b        (data_in),
    .carry_in (1'b0),
    .sum      (add_sum_s),
    .overflow (add_ovf_s)
  );

  // Accept qualifier and "this accept completes the batch" detect.
  // clear blocks acceptance even though data_ready may read 1.
  always_comb begin
    accept_s = data_valid && data_ready && !clear;
    last_s   = (count_q + 8'd1) == LAST_COUNT;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear has priority over accept and result_ack.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = last_s ? ST_DONE : ST_ACCUM;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s && last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (result_ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    data_ready = 1'b0;
    sum_valid  = 1'b0;
    case (state_q)
      ST_IDLE:  data_ready = 1'b1;
      ST_ACCUM: data_ready = 1'b1;
      ST_DONE:  sum_valid  = 1'b1;
      default: begin
        data_ready = 1'b0;
        sum_valid  = 1'b0;
      end
    endcase
  end

  // Datapath next-state: zero on clear or on leaving DONE, update on accept.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear || (state_q == ST_DONE && result_ack)) begin
      acc_d   = 16'd0;
      count_d = 8'd0;
      ovf_d   = 1'b0;
    end else if (accept_s) begin
      acc_d   = add_sum_s;
      count_d = count_q + 8'd1;
      ovf_d   = ovf_q | add_ovf_s;
    end else begin
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q   <= 16'd0;
      count_q <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_out       = acc_q;
  assign overflow_flag = ovf_q;
  assign sample_count  = count_q;

endmodule

// File: tb/tb_sample_accumulator.sv
// Directed bench for sample_accumulator with NUM_SAMPLES=4.
// Inputs change just after the falling edge; outputs are checked at the
// falling edge, half a period away from the active rising edge.
module tb_sample_accumulator;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] sum_out;
  logic        sum_valid;
  logic        result_ack;
  logic        overflow_flag;
  logic [7:0]  sample_count;

  int checks;
  int errors;

  sample_accumulator #(.NUM_SAMPLES(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .sum_out       (sum_out),
    .sum_valid     (sum_valid),
    .result_ack    (result_ack),
    .overflow_flag (overflow_flag),
    .sample_count  (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample for one cycle, then land on the next falling edge.
  task automatic send(input logic [15:0] v);
    data_in    = v;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    data_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_done(input string tag, input logic [15:0] s, input logic [7:0] c, input logic o);
    check_eq({tag, "_valid"}, 32'(sum_valid), 32'd1);
    check_eq({tag, "_ready"}, 32'(data_ready), 32'd0);
    check_eq({tag, "_sum"},   32'(sum_out), 32'(s));
    check_eq({tag, "_cnt"},   32'(sample_count), 32'(c));
    check_eq({tag, "_ovf"},   32'(overflow_flag), 32'(o));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 32'(sum_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(data_ready), 32'd1);
    check_eq({tag, "_sum"},   32'(sum_out), 32'd0);
    check_eq({tag, "_cnt"},   32'(sample_count), 32'd0);
    check_eq({tag, "_ovf"},   32'(overflow_flag), 32'd0);
  endtask

  task automatic ack_once();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    n_rst      = 1'b0;
    clear      = 1'b0;
    data_in    = 16'd0;
    data_valid = 1'b0;
    result_ack = 1'b0;

    repeat (2) @(negedge clk);
    check_idle("rst");
    n_rst = 1'b1;
    @(negedge clk);

    // Back-to-back batch 1..4 -> 10.
    send(16'd1);
    send(16'd2);
    check_eq("b2b_mid_cnt", 32'(sample_count), 32'd2);
    check_eq("b2b_mid_sv",  32'(sum_valid), 32'd0);
    send(16'd3);
    send(16'd4);
    check_done("b2b", 16'd10, 8'd4, 1'b0);
    ack_once();
    check_idle("b2b_ack");

    // Wrap: FFFF + 2 = 0001 with carry; flag sticks to DONE, clears on ack.
    send(16'hFFFF);
    send(16'h0002);
    check_eq("wrap_mid_sum", 32'(sum_out), 32'h0001);
    check_eq("wrap_mid_ovf", 32'(overflow_flag), 32'd1);
    send(16'h0000);
    send(16'h0000);
    check_done("wrap", 16'h0001, 8'd4, 1'b1);
    ack_once();
    check_idle("wrap_ack");

    // Gapped valid: 5, -, -, 7, -, 9, 11 -> 32.
    send(16'd5);
    idle_cycle();
    idle_cycle();
    check_eq("gap_cnt1", 32'(sample_count), 32'd1);
    check_eq("gap_sum1", 32'(sum_out), 32'd5);
    send(16'd7);
    idle_cycle();
    check_eq("gap_cnt2", 32'(sample_count), 32'd2);
    send(16'd9);
    send(16'd11);
    check_done("gap", 16'd32, 8'd4, 1'b0);

    // DONE hold: valid data ignored for 3 cycles.
    data_in    = 16'h1234;
    data_valid = 1'b1;
    repeat (3) @(negedge clk);
    data_valid = 1'b0;
    check_done("hold", 16'd32, 8'd4, 1'b0);
    ack_once();
    check_idle("hold_ack");
    send(16'd10);
    send(16'd20);
    send(16'd30);
    send(16'd40);
    check_done("after_hold", 16'd100, 8'd4, 1'b0);
    ack_once();

    // result_ack held high throughout: ignored in ACCUM, one DONE cycle.
    result_ack = 1'b1;
    send(16'd1);
    send(16'd2);
    send(16'd3);
    check_eq("ackhi_cnt", 32'(sample_count), 32'd3);
    send(16'd4);
    check_done("ackhi", 16'd10, 8'd4, 1'b0);
    @(negedge clk);
    result_ack = 1'b0;
    check_idle("ackhi_next");

    // clear with a valid sample: not accepted, back to zeros.
    send(16'd100);
    send(16'd200);
    check_eq("clr_pre_sum", 32'(sum_out), 32'd300);
    clear      = 1'b1;
    data_in    = 16'd300;
    data_valid = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    data_valid = 1'b0;
    check_idle("clr");
    send(16'd1);
    send(16'd1);
    send(16'd1);
    send(16'd1);
    check_done("clr_next", 16'd4, 8'd4, 1'b0);

    // clear beats result_ack in DONE.
    clear      = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    result_ack = 1'b0;
    check_idle("clr_done");

    // Asynchronous reset mid-ACCUM after three samples.
    send(16'd7);
    send(16'd8);
    send(16'd9);
    check_eq("rst_pre_cnt", 32'(sample_count), 32'd3);
    #2;
    n_rst = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_idle("rst_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
